// File: rtl/uart_pkg.sv
// Shared types and width helpers for the configurable UART receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // Bits needed to count 0..n-1 (at least one bit).
   function automatic int unsigned ctrWidth(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Rx synchroniser plus 3-sample majority voter around the bit centre.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                               Clock,
   input  logic                               Reset,
   input  logic                               Rx,
   input  logic                               Tick,
   input  logic [ctrWidth(OVERSAMPLE)-1:0]    phase,
   output logic                               rxSync,
   output logic                               vote_c,
   output logic                               voteStrobe_c
);

   localparam int unsigned PW = ctrWidth(OVERSAMPLE);
   localparam int unsigned HALF = OVERSAMPLE / 2;
   localparam logic [PW-1:0] PH_EARLY = PW'(HALF - 1);
   localparam logic [PW-1:0] PH_MID   = PW'(HALF);
   localparam logic [PW-1:0] PH_LATE  = PW'(HALF + 1);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   sampEarly;
   logic                   sampMid;

   // Synchroniser chain, idles high.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) syncQ <= '1;
      else       syncQ <= {syncQ[SYNC_STAGES-2:0], Rx};
   end

   assign rxSync = syncQ[SYNC_STAGES-1];

   // Capture the two early samples; the third is taken live at the decision Tick.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sampEarly <= 1'b1;
         sampMid   <= 1'b1;
      end else if (Tick) begin
         if (phase == PH_EARLY) sampEarly <= rxSync;
         if (phase == PH_MID)   sampMid   <= rxSync;
      end
   end

   assign vote_c       = (sampEarly & sampMid) | (sampEarly & rxSync) | (sampMid & rxSync);
   assign voteStrobe_c = Tick && (phase == PH_LATE);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM, counters, shift register and flags.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Rx,
   input  logic                 Tick,
   output logic                 RxValid,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 ParityError,
   output logic                 FramingError,
   output logic                 Busy
);

   localparam int unsigned PW = ctrWidth(OVERSAMPLE);
   localparam int unsigned BW = ctrWidth(maxU(DATA_BITS, STOP_BITS));
   localparam logic [PW-1:0] PH_LAST   = PW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam parity_e PAR = parity_e'(2'(PARITY));

   rx_state_e            state, stateNext;
   logic [PW-1:0]        phase, phaseNext;
   logic [BW-1:0]        bitCnt, bitCntNext;
   logic [DATA_BITS-1:0] shiftReg, shiftNext;
   logic                 parPend, parPendNext;
   logic                 frmPend, frmPendNext;
   logic                 validNext;
   logic [DATA_BITS-1:0] dataNext;
   logic                 parOutNext, frmOutNext;
   logic                 rxSync, vote_c, voteStrobe_c, wrap_c, parSum_c;

   uart_rx_sampler #(
      .OVERSAMPLE  (OVERSAMPLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) uSampler (
      .Clock        (Clock),
      .Reset        (Reset),
      .Rx           (Rx),
      .Tick         (Tick),
      .phase        (phase),
      .rxSync       (rxSync),
      .vote_c       (vote_c),
      .voteStrobe_c (voteStrobe_c)
   );

   assign wrap_c   = Tick && (phase == PH_LAST);
   assign parSum_c = (^shiftReg) ^ vote_c;

   // State, counters, datapath and registered outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= ST_IDLE;
         phase        <= '0;
         bitCnt       <= '0;
         shiftReg     <= '0;
         parPend      <= 1'b0;
         frmPend      <= 1'b0;
         RxValid      <= 1'b0;
         RxData       <= '0;
         ParityError  <= 1'b0;
         FramingError <= 1'b0;
         Busy         <= 1'b0;
      end else begin
         state        <= stateNext;
         phase        <= phaseNext;
         bitCnt       <= bitCntNext;
         shiftReg     <= shiftNext;
         parPend      <= parPendNext;
         frmPend      <= frmPendNext;
         RxValid      <= validNext;
         RxData       <= dataNext;
         ParityError  <= parOutNext;
         FramingError <= frmOutNext;
         Busy         <= (stateNext != ST_IDLE);
      end
   end

   // Next-state and next-value logic; decisions land on the phase HALF+1 Tick.
   always_comb begin
      stateNext   = state;
      phaseNext   = phase;
      bitCntNext  = bitCnt;
      shiftNext   = shiftReg;
      parPendNext = parPend;
      frmPendNext = frmPend;
      validNext   = 1'b0;
      dataNext    = RxData;
      parOutNext  = ParityError;
      frmOutNext  = FramingError;

      if ((state != ST_IDLE) && Tick) phaseNext = phase + PW'(1);

      case (state)
         ST_IDLE: begin
            if (!rxSync) begin
               stateNext   = ST_START;
               phaseNext   = '0;
               bitCntNext  = '0;
               parPendNext = 1'b0;
               frmPendNext = 1'b0;
            end
         end
         ST_START: begin
            if (voteStrobe_c && vote_c) stateNext = ST_IDLE;
            else if (wrap_c)            stateNext = ST_DATA;
         end
         ST_DATA: begin
            if (voteStrobe_c) shiftNext = {vote_c, shiftReg[DATA_BITS-1:1]};
            if (wrap_c) begin
               if (bitCnt == DATA_LAST) begin
                  bitCntNext = '0;
                  stateNext  = (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  bitCntNext = bitCnt + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (voteStrobe_c) parPendNext = (PAR == PAR_ODD) ? ~parSum_c : parSum_c;
            if (wrap_c) begin
               stateNext  = ST_STOP;
               bitCntNext = '0;
            end
         end
         ST_STOP: begin
            if (voteStrobe_c) begin
               if (!vote_c) frmPendNext = 1'b1;
               if (bitCnt == STOP_LAST) begin
                  validNext  = 1'b1;
                  dataNext   = shiftReg;
                  parOutNext = parPend;
                  frmOutNext = frmPend | ~vote_c;
                  stateNext  = ST_IDLE;
               end
            end else if (wrap_c) begin
               bitCntNext = bitCnt + BW'(1);
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 8N2 instances on a shared Tick.
module tb_uart_rx_cfg;

   logic       Clock;
   logic       Reset;
   logic       Tick;
   logic       rx       [3];
   logic       rxValid  [3];
   logic [7:0] rxData   [3];
   logic       parErr   [3];
   logic       frmErr   [3];
   logic       busy     [3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic [7:0] expData;
      logic       expPe;
      logic       expFe;
   } cap_t;

   cap_t capQ[$];

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       hasPar;
      logic       parBit;
      int         nStop;
      logic [1:0] stopVals;
      logic [7:0] expData;
      logic       expPe;
      logic       expFe;
   } vec_t;

   vec_t vecs[8];

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u8n1 (
      .Clock(Clock), .Reset(Reset), .Rx(rx[0]), .Tick(Tick), .RxValid(rxValid[0]), .RxData(rxData[0]),
      .ParityError(parErr[0]), .FramingError(frmErr[0]), .Busy(busy[0]));

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u8e1 (
      .Clock(Clock), .Reset(Reset), .Rx(rx[1]), .Tick(Tick), .RxValid(rxValid[1]), .RxData(rxData[1]),
      .ParityError(parErr[1]), .FramingError(frmErr[1]), .Busy(busy[1]));

   uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(2)) u8n2 (
      .Clock(Clock), .Reset(Reset), .Rx(rx[2]), .Tick(Tick), .RxValid(rxValid[2]), .RxData(rxData[2]),
      .ParityError(parErr[2]), .FramingError(frmErr[2]), .Busy(busy[2]));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Log every completed frame; sampled mid-cycle so a one-Clock pulse logs once.
   always @(negedge Clock) begin
      for (int k = 0; k < 3; k++) begin
         if (rxValid[k] === 1'b1) capQ.push_back('{k, rxData[k], 8'h00, parErr[k], frmErr[k]});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clock) Tick = 1'b1;
      @(negedge Clock) Tick = 1'b0;
      @(negedge Clock);
   endtask

   task automatic sendBit(input int k, input logic v, input int n);
      rx[k] = v;
      repeat (n) tick();
   endtask

   task automatic sendFrame(input int k, input logic [7:0] d, input logic hasPar, input logic pb,
                            input int nStop, input logic [1:0] sv, input int gap);
      sendBit(k, 1'b0, 16);
      for (int i = 0; i < 8; i++) sendBit(k, d[i], 16);
      if (hasPar) sendBit(k, pb, 16);
      for (int s = 0; s < nStop; s++) sendBit(k, sv[s], 16);
      sendBit(k, 1'b1, gap);
   endtask

   task automatic checkOneFrame(input string tag, input int k, input logic [7:0] ed,
                                input logic epe, input logic efe);
      check({tag, "_count"}, 32'(capQ.size()), 32'd1);
      if (capQ.size() > 0) begin
         check({tag, "_inst"}, 32'(capQ[0].inst), 32'(k));
         check({tag, "_data"}, 32'(capQ[0].data), 32'(ed));
         check({tag, "_perr"}, 32'(capQ[0].expPe), 32'(epe));
         check({tag, "_ferr"}, 32'(capQ[0].expFe), 32'(efe));
      end
      check({tag, "_busy"}, 32'(busy[k]), 32'd0);
   endtask

   initial begin
      // inst, data, hasPar, parBit, nStop, stopVals, expData, expPe, expFe
      vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{1, 8'h3C, 1'b1, 1'b0, 1, 2'b01, 8'h3C, 1'b0, 1'b0};
      vecs[2] = '{1, 8'h3C, 1'b1, 1'b1, 1, 2'b01, 8'h3C, 1'b1, 1'b0};
      vecs[3] = '{0, 8'h00, 1'b0, 1'b0, 1, 2'b00, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{2, 8'h81, 1'b0, 1'b0, 2, 2'b11, 8'h81, 1'b0, 1'b0};
      vecs[5] = '{2, 8'h00, 1'b0, 1'b0, 2, 2'b01, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{1, 8'h07, 1'b1, 1'b1, 1, 2'b01, 8'h07, 1'b0, 1'b0};
      vecs[7] = '{0, 8'h5A, 1'b0, 1'b0, 1, 2'b01, 8'h5A, 1'b0, 1'b0};

      Tick = 1'b0;
      for (int k = 0; k < 3; k++) rx[k] = 1'b1;
      Reset = 1'b1;
      repeat (4) @(negedge Clock);
      check("reset_valid", 32'(rxValid[0]), 32'd0);
      check("reset_data",  32'(rxData[0]),  32'd0);
      check("reset_perr",  32'(parErr[1]),  32'd0);
      check("reset_ferr",  32'(frmErr[2]),  32'd0);
      check("reset_busy",  32'(busy[0]),    32'd0);
      Reset = 1'b0;
      repeat (4) tick();

      // Table-driven frames.
      for (int v = 0; v < 8; v++) begin
         capQ.delete();
         sendFrame(vecs[v].inst, vecs[v].data, vecs[v].hasPar, vecs[v].parBit,
                   vecs[v].nStop, vecs[v].stopVals, 24);
         checkOneFrame($sformatf("vec%0d", v), vecs[v].inst, vecs[v].expData, vecs[v].expPe, vecs[v].expFe);
      end

      // Glitch: 4 Ticks low is rejected as a false start.
      capQ.delete();
      sendBit(0, 1'b0, 4);
      check("glitch_busy_hi", 32'(busy[0]), 32'd1);
      sendBit(0, 1'b1, 12);
      check("glitch_busy_lo", 32'(busy[0]), 32'd0);
      sendBit(0, 1'b1, 12);
      check("glitch_count", 32'(capQ.size()), 32'd0);
      check("glitch_data",  32'(rxData[0]), 32'h5A);

      // Reset during data bit 4 discards the frame and clears outputs.
      capQ.delete();
      sendBit(0, 1'b0, 16);
      for (int i = 0; i < 4; i++) sendBit(0, 1'b1, 16);
      sendBit(0, 1'b1, 5);
      check("midrst_busy_pre", 32'(busy[0]), 32'd1);
      Reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_data", 32'(rxData[0]), 32'd0);
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      sendBit(0, 1'b1, 24);
      check("midrst_count", 32'(capQ.size()), 32'd0);
      check("midrst_data2", 32'(rxData[0]), 32'd0);

      // Back-to-back frames with no idle gap.
      capQ.delete();
      sendFrame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b01, 0);
      sendFrame(0, 8'hC3, 1'b0, 1'b0, 1, 2'b01, 24);
      check("b2b_count", 32'(capQ.size()), 32'd2);
      if (capQ.size() == 2) begin
         check("b2b_data0", 32'(capQ[0].data), 32'h5A);
         check("b2b_data1", 32'(capQ[1].data), 32'hC3);
         check("b2b_ferr1", 32'(capQ[1].expFe), 32'd0);
      end
      check("b2b_busy", 32'(busy[0]), 32'd0);

      // Noise: single-Tick inversion near the centre of data bit 3 is voted out.
      capQ.delete();
      sendBit(0, 1'b0, 16);
      for (int i = 0; i < 3; i++) sendBit(0, 1'b0, 16);
      sendBit(0, 1'b0, 8);
      sendBit(0, 1'b1, 1);
      sendBit(0, 1'b0, 7);
      for (int i = 4; i < 8; i++) sendBit(0, 1'b0, 16);
      sendBit(0, 1'b1, 16);
      sendBit(0, 1'b1, 24);
      checkOneFrame("noise", 0, 8'h00, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of our fixed 8N1 receiver. It adds configurable data width, oversampling ratio, parity and stop-bit count, plus an input synchroniser, 3-sample majority voting, false-start rejection and error flags. It sits between the Rx pad and the byte consumer (RX FIFO or register block). It is driven by the shared baud-rate generator's Tick.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
OVERSAMPLE, 16, Tick pulses per bit; power of two, 8..64.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits checked; 1 or 2.
SYNC_STAGES, 2, flops in the Rx synchroniser; at least 2.

Ports:
Clock  in  1  system clock; all logic on its rising edge.
Reset  in  1  asynchronous, active-high reset.
Rx  in  1  asynchronous serial input; idles high.
Tick  in  1  one-Clock pulse at OVERSAMPLE x baud.
RxValid  out  1  one-Clock pulse: frame complete, data and flags valid.
RxData  out  DATA_BITS  received word, LSB received first.
ParityError  out  1  parity mismatch in the last completed frame; 0 when PARITY = 0.
FramingError  out  1  a stop bit sampled 0 in the last completed frame.
Busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0.
  - Synchroniser flops go to 1 (line idle).
  - FSM goes to IDLE; all counters clear.
- Synchroniser: Rx passes through SYNC_STAGES flops; rxs is the last stage.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - Phase counter: log2(OVERSAMPLE) bits, wraps modulo OVERSAMPLE, increments only on Tick.
  - Bit counter: sized for max(DATA_BITS, STOP_BITS) - 1.
- HALF = OVERSAMPLE/2.
- Sampling:
  - rxs is sampled on Ticks with phase HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples.
  - The decision is taken on the Tick with phase HALF+1.
- IDLE: rxs == 0 on any Clock moves to START, with phase = 0 and bit counter = 0. No Tick is required.
- START, at the decision point:
  - Vote 1 is a false start: return to IDLE, no RxValid, outputs unchanged.
  - Vote 0 enters DATA on the next phase wrap.
- DATA:
  - Each vote is shifted into the MSB of the shift register (LSB-first line order).
  - After DATA_BITS votes go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - Compute the XOR of the data bits and the parity vote.
  - Error if the result is 0 for odd parity, or 1 for even parity.
- STOP:
  - Vote each of STOP_BITS bits; any 0 vote sets the pending framing error.
  - At the decision point of the last stop bit:
    - latch RxData, ParityError and FramingError;
    - pulse RxValid for exactly one Clock, registered, in the Clock after that Tick;
    - return to IDLE.
  - The FSM does not wait for the bit end, so the next start edge can be detected within half a bit.
- Output hold: RxData and both error flags hold until the next completed frame. False starts and resets mid-frame never update them (except that reset clears them).
- Break (line held 0): completes as data = 0 with FramingError = 1. The FSM then stays in IDLE, re-triggering on every Clock while the line remains low. Each re-trigger is rejected as a false start only if the vote is 1, so a sustained break yields repeated framing-error frames. This is acceptable and documented.
- Tick high on consecutive Clocks: each Clock counts as a Tick; no special case.
- Reset mid-frame: frame is discarded, no RxValid, Busy drops asynchronously.
- Widths: parity is a reduction XOR over DATA_BITS; no arithmetic wider than the counters.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx_state_e enum (the five states);
  - function clog2-based width helpers.
- One sub-module, uart_rx_sampler: the synchroniser plus 3-sample majority voter. It takes phase and Tick and outputs a vote bit and a vote-strobe. The FSM, counters and shift register stay in uart_rx_cfg.

Test Plan:
1. 8N1, OVERSAMPLE = 16, send 0xA5 → single RxValid pulse, RxData = 0xA5, ParityError = 0, FramingError = 0, Busy low afterwards.
2. Even parity:
   - send 0x3C with parity bit 0 → ParityError = 0;
   - send 0x3C with parity bit 1 → RxData = 0x3C, ParityError = 1.
3. Glitch: Rx low for 4 Ticks then high → no RxValid, RxData unchanged, Busy high then low by Tick 9.
4. Stop bit driven 0 on frame 0x00 → RxValid, RxData = 0x00, FramingError = 1. With STOP_BITS = 2, only the second stop low → FramingError = 1.
5. Noise: invert Rx for 1 Tick at phase HALF of data bit 3 while sending 0x00 → RxData = 0x00, no errors.
6. Robustness:
   - assert Reset during data bit 4 → Busy = 0, no RxValid, RxData = 0x00;
   - then send 0x5A and 0xC3 back-to-back (8N1, no gap) → two RxValid pulses with RxData = 0x5A then 0xC3.
